// File: rtl/_srcenc.sv
// ---------------------------------------------------------------------------
// _srcenc : immediate source-data encoder
//
// Takes a 32-bit constant and finds the (srcdat, srcop) immediate pair that the
// execute-unit source generator expands back to exactly that value. If no pair
// exists, the result is a miss. The block is a two-stage valid/ready pipeline:
// stage 1 evaluates every encodable form in parallel, and stage 2 resolves the
// winning form by fixed priority. Hit and miss statistics are kept in
// saturating counters.
//
// Ports
//   sys_clk, resetl      clock, asynchronous active-low reset
//   flush                synchronous pipeline flush (counters untouched)
//   in_valid/in_ready    request handshake
//   in_value             constant to encode
//   in_pc                program count sampled with the request (type 7)
//   in_tag               sideband tag carried with the request
//   out_valid/out_ready  result handshake
//   out_hit              encoding found
//   out_srcdat/srcop     encoding (0/0 on miss)
//   out_tag              tag of this result
//   hit_count/miss_count saturating delivery counters
//   cnt_clear            synchronous counter clear (wins over increment)
// ---------------------------------------------------------------------------
module _srcenc #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned USE_PC = 1
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic [31:0]      in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [3:0]       out_srcdat,
  output logic [4:0]       out_srcop,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  input  logic             cnt_clear
);

  // Source type codes as understood by the generator.
  localparam logic [3:0] SRC_NONE    = 4'd0;
  localparam logic [3:0] SRC_SMALL   = 4'd1;
  localparam logic [3:0] SRC_QUAD    = 4'd2;
  localparam logic [3:0] SRC_NEG     = 4'd3;
  localparam logic [3:0] SRC_ZERO    = 4'd4;
  localparam logic [3:0] SRC_ONES    = 4'd6;
  localparam logic [3:0] SRC_PC      = 4'd7;
  localparam logic [3:0] SRC_CONST32 = 4'd8;
  localparam logic [3:0] SRC_BITSET  = 4'd9;
  localparam logic [3:0] SRC_BITCLR  = 4'd10;

  // Match flag positions.
  localparam int unsigned F_ZERO    = 0;
  localparam int unsigned F_ONES    = 1;
  localparam int unsigned F_SMALL   = 2;
  localparam int unsigned F_NEG     = 3;
  localparam int unsigned F_CONST32 = 4;
  localparam int unsigned F_QUAD    = 5;
  localparam int unsigned F_BITSET  = 6;
  localparam int unsigned F_BITCLR  = 7;
  localparam int unsigned F_PC      = 8;
  localparam int unsigned NFLAGS    = 9;

  // Position of the highest set bit; only meaningful for one-hot inputs.
  function automatic logic [4:0] bit_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // -------------------------------------------------------------------------
  // Handshake / advance control
  // -------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [6:0]       s1_lo_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [NFLAGS-1:0] s1_flags_q, s1_flags_d;
  logic [4:0]       s1_idx_set_q, s1_idx_clr_q;

  logic             out_valid_q, out_valid_d;
  logic             out_hit_q;
  logic [3:0]       out_srcdat_q;
  logic [4:0]       out_srcop_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic s2_adv, s1_adv, s1_load, s2_load, out_hs;

  assign s2_adv  = ~out_valid_q | out_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  // During a flush everything is discarded, so any offered request may be taken.
  assign in_ready = s1_adv | flush;
  assign s1_load = s1_adv & in_valid & ~flush;
  assign s2_load = s2_adv & s1_valid_q & ~flush;
  assign out_hs  = out_valid_q & out_ready;

  // -------------------------------------------------------------------------
  // Stage 1: evaluate all encodable forms in parallel
  // -------------------------------------------------------------------------
  always_comb begin
    s1_flags_d            = '0;
    s1_flags_d[F_ZERO]    = (in_value == 32'h0000_0000);
    s1_flags_d[F_ONES]    = (in_value == 32'hFFFF_FFFF);
    s1_flags_d[F_SMALL]   = (in_value <= 32'd31);
    s1_flags_d[F_NEG]     = &in_value[31:5];
    s1_flags_d[F_CONST32] = (in_value == 32'd32);
    s1_flags_d[F_QUAD]    = (in_value[1:0] == 2'b00) && (in_value >= 32'd4) &&
                            (in_value <= 32'd128);
    s1_flags_d[F_BITSET]  = is_onehot(in_value);
    s1_flags_d[F_BITCLR]  = is_onehot(~in_value);
    s1_flags_d[F_PC]      = (USE_PC != 0) && (in_value == in_pc);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)       s1_valid_d = 1'b0;
    else if (s1_adv) s1_valid_d = in_valid;
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      s1_valid_q   <= 1'b0;
      s1_lo_q      <= '0;
      s1_tag_q     <= '0;
      s1_flags_q   <= '0;
      s1_idx_set_q <= '0;
      s1_idx_clr_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_lo_q      <= in_value[6:0];
        s1_tag_q     <= in_tag;
        s1_flags_q   <= s1_flags_d;
        s1_idx_set_q <= bit_index(in_value);
        s1_idx_clr_q <= bit_index(~in_value);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: fixed-priority resolution, first match wins
  // -------------------------------------------------------------------------
  logic       enc_hit;
  logic [3:0] enc_srcdat;
  logic [4:0] enc_srcop;

  always_comb begin
    enc_hit    = 1'b1;
    enc_srcdat = SRC_NONE;
    enc_srcop  = 5'd0;
    if (s1_flags_q[F_ZERO]) begin
      enc_srcdat = SRC_ZERO;
    end else if (s1_flags_q[F_ONES]) begin
      enc_srcdat = SRC_ONES;
    end else if (s1_flags_q[F_SMALL]) begin
      enc_srcdat = SRC_SMALL;
      enc_srcop  = s1_lo_q[4:0];
    end else if (s1_flags_q[F_NEG]) begin
      enc_srcdat = SRC_NEG;
      enc_srcop  = s1_lo_q[4:0];
    end else if (s1_flags_q[F_CONST32]) begin
      // 32 is the wrapped encoding of the 1..32 range.
      enc_srcdat = SRC_CONST32;
    end else if (s1_flags_q[F_QUAD]) begin
      // Word multiples; 128 wraps to operand 0.
      enc_srcdat = SRC_QUAD;
      enc_srcop  = s1_lo_q[6:2];
    end else if (s1_flags_q[F_BITSET]) begin
      enc_srcdat = SRC_BITSET;
      enc_srcop  = s1_idx_set_q;
    end else if (s1_flags_q[F_BITCLR]) begin
      enc_srcdat = SRC_BITCLR;
      enc_srcop  = s1_idx_clr_q;
    end else if (s1_flags_q[F_PC]) begin
      enc_srcdat = SRC_PC;
    end else begin
      enc_hit = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)       out_valid_d = 1'b0;
    else if (s2_adv) out_valid_d = s1_valid_q;
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_srcdat_q <= '0;
      out_srcop_q  <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        out_hit_q    <= enc_hit;
        out_srcdat_q <= enc_srcdat;
        out_srcop_q  <= enc_srcop;
        out_tag_q    <= s1_tag_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating delivery counters; clear wins over a same-cycle increment
  // -------------------------------------------------------------------------
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clear) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (out_hs) begin
      if (out_hit_q) begin
        if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else begin
        if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_srcdat = out_srcdat_q;
  assign out_srcop  = out_srcop_q;
  assign out_tag    = out_tag_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
